// File: rtl/fetch_unit.sv
// fetch_unit: PC register and instruction-fetch stage.
// Drives a synchronous ROM; applies relative branches and halts.
module fetch_unit #(
  parameter int unsigned          PC_W       = 10,
  parameter int unsigned          INSTR_W    = 9,
  parameter logic [PC_W-1:0]      START_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [7:0]         branch_offset,
  input  logic               halt,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   d_pc_q, d_pc_d;
  logic              d_valid_q, d_valid_d;
  logic              done_q, done_d;
  logic [PC_W-1:0]   off_ext;
  logic              run;

  assign run         = (state_q == RUN);
  assign off_ext     = {{(PC_W-8){branch_offset[7]}}, branch_offset};
  assign imem_addr   = pc_q;
  assign imem_en     = run && !stall;
  assign instr       = imem_data;
  assign instr_pc    = d_pc_q;
  assign instr_valid = d_valid_q && run;
  assign done        = done_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    d_pc_d    = d_pc_q;
    d_valid_d = d_valid_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          d_valid_d = 1'b0;
          done_d    = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (instr_valid && halt) begin
            state_d   = HALTED;
            d_valid_d = 1'b0;
            done_d    = 1'b1;
          end else if (instr_valid && branch_taken) begin
            // the fetch of the old pc_q is wrong-path: squash it
            pc_d      = d_pc_q + off_ext;
            d_valid_d = 1'b0;
          end else begin
            d_pc_d    = pc_q;
            d_valid_d = 1'b1;
            pc_d      = pc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= START_ADDR;
      d_pc_q    <= '0;
      d_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      d_pc_q    <= d_pc_d;
      d_valid_q <= d_valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written reset
// sequence for fetch_unit, with a synchronous ROM model.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stall = 1'b0;
  logic               branch_taken = 1'b0;
  logic [7:0]         branch_offset = '0;
  logic               halt = 1'b0;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_data = '0;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               done;

  int checks = 0;
  int failures = 0;

  fetch_unit #(
    .PC_W(PC_W),
    .INSTR_W(INSTR_W),
    .START_ADDR('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .halt(halt),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_data(imem_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] rom_fn(input logic [PC_W-1:0] a);
    logic [PC_W-1:0] g;
    g = a ^ (a >> 1);
    return g[INSTR_W-1:0] ^ 9'h0A5;
  endfunction

  always @(posedge clk)
    if (imem_en) imem_data <= rom_fn(imem_addr);

  typedef struct {
    bit         rst;
    bit         start;
    bit         stall;
    bit         br;
    logic [7:0] off;
    bit         halt;
    bit         en;
    bit         vld;
    int         pc;
    int         addr;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rst, int st, int sl, int br,
                              int off, int hl, int en, int vld,
                              int pc, int addr, int dn);
    vec_t v;
    v.rst = rst[0]; v.start = st[0]; v.stall = sl[0];
    v.br = br[0]; v.off = off[7:0]; v.halt = hl[0];
    v.en = en[0]; v.vld = vld[0]; v.pc = pc;
    v.addr = addr; v.done = dn[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0d expected=%0d",
               nm, idx, act, exp);
    end
  endtask

  initial begin
    // rst st sl br off   hl | en vld pc   addr dn
    tbl.push_back(mk(1,0,0,0,8'h00,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,2,3,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,3,4,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,4,5,0));
    tbl.push_back(mk(0,0,0,1,8'h1E,0, 1,1,5,6,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,35,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,35,36,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,36,37,0));
    tbl.push_back(mk(1,0,0,0,8'h00,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,0,1,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,2,3,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,3,4,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,4,5,0));
    tbl.push_back(mk(0,0,0,1,8'hE2,0, 1,1,5,6,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,999,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,999,1000,0));
    tbl.push_back(mk(0,0,0,1,8'h17,0, 1,1,1000,1001,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,1023,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,1023,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,0,1,0));
    tbl.push_back(mk(0,0,0,1,8'h06,0, 1,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,7,0));
    tbl.push_back(mk(0,0,1,1,8'h10,0, 0,1,7,8,0));
    tbl.push_back(mk(0,0,1,1,8'h10,0, 0,1,7,8,0));
    tbl.push_back(mk(0,0,1,1,8'h10,0, 0,1,7,8,0));
    tbl.push_back(mk(0,0,0,1,8'h10,0, 1,1,7,8,0));
    tbl.push_back(mk(0,0,1,0,8'h00,0, 0,0,0,23,0));
    tbl.push_back(mk(0,0,0,1,8'h40,0, 1,0,0,23,0));
    tbl.push_back(mk(0,0,0,1,8'hF5,0, 1,1,23,24,0));
    tbl.push_back(mk(0,0,0,0,8'h00,1, 1,0,0,12,0));
    tbl.push_back(mk(0,0,0,1,8'h1E,1, 1,1,12,13,0));
    tbl.push_back(mk(0,0,0,1,8'h1E,0, 0,0,0,13,1));
    tbl.push_back(mk(0,1,0,0,8'h00,0, 0,0,0,13,1));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,0,1,0));
    tbl.push_back(mk(0,1,0,0,8'h00,0, 1,1,1,2,0));
    tbl.push_back(mk(0,0,0,1,8'h12,0, 1,1,2,3,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,0,0,20,0));
    tbl.push_back(mk(0,0,0,0,8'h00,0, 1,1,20,21,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      start         = tbl[i].start;
      stall         = tbl[i].stall;
      branch_taken  = tbl[i].br;
      branch_offset = tbl[i].off;
      halt          = tbl[i].halt;
      rst_n         = !tbl[i].rst;
      #1;
      chk("imem_en", i, int'(imem_en), int'(tbl[i].en));
      chk("instr_valid", i, int'(instr_valid), int'(tbl[i].vld));
      chk("imem_addr", i, int'(imem_addr), tbl[i].addr);
      chk("done", i, int'(done), int'(tbl[i].done));
      if (tbl[i].vld || tbl[i].rst)
        chk("instr_pc", i, int'(instr_pc), tbl[i].pc);
      if (tbl[i].vld)
        chk("instr", i, int'(instr), int'(rom_fn(tbl[i].pc[PC_W-1:0])));
    end

    // asynchronous reset in the same cycle instr_pc=20 is presented
    start = 1'b0; branch_taken = 1'b0; halt = 1'b0; stall = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 100, int'(instr_valid), 0);
    chk("rst_mid_addr", 100, int'(imem_addr), 0);
    chk("rst_mid_done", 100, int'(done), 0);
    chk("rst_mid_en", 100, int'(imem_en), 0);
    chk("rst_mid_pc", 100, int'(instr_pc), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("idle_en", 101 + k, int'(imem_en), 0);
      chk("idle_valid", 101 + k, int'(instr_valid), 0);
    end

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("restart_en", 110, int'(imem_en), 1);
    chk("restart_valid", 110, int'(instr_valid), 0);
    @(negedge clk);
    #1;
    chk("restart_valid2", 111, int'(instr_valid), 1);
    chk("restart_pc", 111, int'(instr_pc), 0);
    chk("restart_instr", 111, int'(instr), int'(rom_fn('0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-fetch stage of the core. It holds the PC and drives the synchronous instruction ROM. It presents each fetched instruction with its PC and a valid flag to decode. It applies relative branches using the signed 8-bit offset produced by the branch-offset lookup table (e.g. +30 / −30), squashing the wrong-path fetch, and stops on a halt instruction.

## Interface
Parameters:
- PC_W, 10, PC / instruction-address width
- INSTR_W, 9, instruction width
- START_ADDR, 0, PC loaded on reset and on every start

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin execution from START_ADDR (honoured in IDLE and HALTED only)
- stall  in  1  freeze PC and presented instruction
- branch_taken  in  1  presented instruction is a taken branch
- branch_offset  in  8  signed two's-complement offset from the lookup table
- halt  in  1  presented instruction is a halt
- imem_addr  out  PC_W  ROM address (= pc_q)
- imem_en  out  1  ROM read enable; ROM holds its output when low
- imem_data  in  INSTR_W  ROM data for the address presented on the previous enabled edge
- instr  out  INSTR_W  presented instruction (= imem_data)
- instr_pc  out  PC_W  PC of presented instruction
- instr_valid  out  1  instr/instr_pc are live
- done  out  1  program halted

## Operation
- States: IDLE, RUN, HALTED.
  - IDLE→RUN on start.
  - RUN→HALTED on accepted halt.
  - HALTED→RUN on start.
  - No other transitions. start is ignored in RUN.
- Registers:
  - pc_q: next fetch address.
  - d_pc_q: PC whose data is on imem_data.
  - d_valid_q: whether that fetch is live.
  - done_q.
- imem_addr = pc_q. imem_en = (state==RUN) && !stall.
- instr = imem_data, instr_pc = d_pc_q, instr_valid = d_valid_q && state==RUN.
- On start (IDLE/HALTED): pc_q←START_ADDR, d_valid_q←0, done_q←0.
- RUN, stall=1: all registers hold. halt and branch_taken are ignored.
- RUN, stall=0, priority halt > branch > increment. halt and branch_taken are only acted on when instr_valid=1.
  - halt: state←HALTED, d_valid_q←0, done_q←1, pc_q holds.
  - branch_taken: pc_q←instr_pc + sext(branch_offset), mod 2^PC_W. d_valid_q←0 (wrong-path fetch of old pc_q squashed).
  - otherwise: d_pc_q←pc_q, d_valid_q←1, pc_q←pc_q+1 mod 2^PC_W.
- Arithmetic:
  - Offset is sign-extended from bit 7 to PC_W bits.
  - Sums and increments wrap silently; no overflow flag.
- Outside RUN, imem_en=0 and instr_valid=0.

## Timing
- Reset values (asynchronous, on rst_n=0):
  - state IDLE, pc_q=START_ADDR, d_pc_q=0, d_valid_q=0, done=0.
  - Hence imem_addr=START_ADDR, imem_en=0, instr_valid=0, instr_pc=0.
- Start latency: start sampled at edge 0 → imem_en=1 in cycle 1 → instr_valid=1, instr_pc=START_ADDR in cycle 2.
- Throughput: one instruction per cycle when unstalled.
- Branch penalty: taken branch accepted at edge n → instr_valid=0 in cycle n+1 → instr_valid=1, instr_pc=target in cycle n+2.
- Halt: accepted at edge n → done=1 and instr_valid=0 from cycle n+1. done holds until start or reset.
- Stall: holds instr/instr_pc/instr_valid unchanged for every stalled cycle, including during a bubble after a branch.
- Boundary cases:
  - Simultaneous halt+branch_taken: halt wins.
  - stall with branch_taken: branch deferred until stall drops.
  - Reset mid-RUN: immediate return to reset values; no partial update.
  - rst_n deassertion is synchronous to clk in the system.

## Test plan
- Reset, start pulse, no stalls, START_ADDR=0 → instr_valid first high two cycles after start with instr_pc=0, then 1, 2, 3 on consecutive cycles; done=0.
- At instr_pc=5, branch_taken with offset 8'h1E (+30) → one bubble, then instr_pc=35, 36. At instr_pc=5 with offset 8'hE2 (−30), PC_W=10 → one bubble, then instr_pc=999.
- pc_q running to 1023 → next instr_pc after 1023 is 0, no bubble.
- stall held 3 cycles while instr_pc=7 with branch_taken=1 → outputs frozen at 7 for 3 cycles, imem_en=0; branch taken on the first unstalled edge.
- halt and branch_taken together at instr_pc=12 → done=1 next cycle, instr_valid=0, PC not redirected. Subsequent start → done=0, fetch restarts at START_ADDR.
- rst_n low mid-RUN at instr_pc=20 → same cycle: instr_valid=0, imem_addr=START_ADDR, done=0. After release, stays IDLE until start.
